// File: rtl/mips_mem_pkg.sv
// Shared types and address decoding for the mips_mem memory responder.
package mips_mem_pkg;

    // Controller state: program-load phase, then normal core service.
    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [31:0] OOR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Decoded view of a core byte address.
    typedef struct packed {
        logic [31:0] off;       // byte offset from the base (wraps)
        logic [29:0] idx;       // word index; callers keep the low log2(depth) bits
        logic        in_range;  // offset lands inside the array
        logic        aligned;   // low two address bits are zero
    } word_map_t;

    // Map a byte address onto the word array; the low two bits never affect the index.
    function automatic word_map_t word_idx(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] depth_words);
        word_map_t m;
        m.off      = addr - base;
        m.idx      = m.off[31:2];
        m.in_range = ({2'b00, m.idx} < depth_words);
        m.aligned  = (addr[1:0] == 2'b00);
        return m;
    endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Word storage: one write port and NRD registered, write-first read ports.
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS),
    parameter int NRD         = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en_i,
    input  logic [AW-1:0]           wr_addr_i,
    input  logic [31:0]             wr_data_i,
    input  logic [NRD-1:0]          rd_en_i,
    input  logic [NRD-1:0][AW-1:0]  rd_addr_i,
    output logic [NRD-1:0][31:0]    rd_data_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Storage write; contents survive reset so a reloaded image can be partial.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [31:0] rd_q;

            // Registered read; a same-cycle write to the same word is forwarded.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_q <= '0;
                end else if (rd_en_i[gi]) begin
                    rd_q <= (wr_en_i && (wr_addr_i == rd_addr_i[gi])) ? wr_data_i
                                                                       : mem_q[rd_addr_i[gi]];
                end
            end

            assign rd_data_o[gi] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/mips_mem.sv
// Memory responder for the mips core: instruction and data ports with a
// front-end program loader that holds the core in reset until loading ends.
module mips_mem
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter bit          LOAD_EN     = 1'b1,
    parameter logic [31:0] OOR_DATA    = OOR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_data,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_rd_wr,
    output logic [31:0] data_rdata,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        core_run,
    output logic        err_range,
    output logic        err_align
);

    localparam int     AW          = $clog2(DEPTH_WORDS);
    localparam state_t RESET_STATE = LOAD_EN ? LOAD : RUN;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH_WORDS - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            core_run_q, core_run_d;
    logic            err_range_q, err_range_d;
    logic            err_align_q, err_align_d;
    logic            instr_oor_q, instr_oor_d;
    logic            data_oor_q, data_oor_d;

    word_map_t       imap, dmap;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [31:0]     wr_data;
    logic [1:0]      rd_en;
    logic [1:0][AW-1:0] rd_addr;
    logic [1:0][31:0]   rd_data;

    assign imap = word_idx(instr_addr, ADDR_BASE, 32'(DEPTH_WORDS));
    assign dmap = word_idx(data_addr, ADDR_BASE, 32'(DEPTH_WORDS));

    // Read port 0 serves instruction fetch, port 1 serves data loads.
    assign rd_addr = {dmap.idx[AW-1:0], imap.idx[AW-1:0]};

    // Offset and upper index bits are only consumed through the range flag.
    logic unused_map_bits;
    assign unused_map_bits = ^{imap.off, imap.idx[29:AW], dmap.off, dmap.idx[29:AW]};

    mips_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW),
        .NRD         (2)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // Next-state: loader handshake in LOAD, core port service and error capture in RUN.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        core_run_d  = core_run_q;
        err_range_d = err_range_q;
        err_align_d = err_align_q;
        instr_oor_d = instr_oor_q;
        data_oor_d  = data_oor_q;
        wr_en       = 1'b0;
        wr_addr     = ptr_q;
        wr_data     = ld_data;
        rd_en       = 2'b00;

        case (state_q)
            LOAD: begin
                if (ld_valid) begin
                    wr_en = 1'b1;
                    if (ld_last || (ptr_q == LAST_PTR)) begin
                        state_d = RUN;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            RUN: begin
                core_run_d  = 1'b1;
                rd_en       = 2'b11;
                instr_oor_d = !imap.in_range;
                data_oor_d  = !dmap.in_range;
                wr_addr     = dmap.idx[AW-1:0];
                wr_data     = data_wdata;
                if (!imap.in_range) err_range_d = 1'b1;
                if (!imap.aligned)  err_align_d = 1'b1;
                // Loads never flag errors: the core drives data_addr every instruction.
                if (!data_rd_wr) begin
                    if (!dmap.in_range) err_range_d = 1'b1;
                    if (!dmap.aligned)  err_align_d = 1'b1;
                    wr_en = dmap.in_range && dmap.aligned;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Control and flag registers; memory contents are deliberately not reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RESET_STATE;
            ptr_q       <= '0;
            core_run_q  <= 1'b0;
            err_range_q <= 1'b0;
            err_align_q <= 1'b0;
            instr_oor_q <= 1'b0;
            data_oor_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            core_run_q  <= core_run_d;
            err_range_q <= err_range_d;
            err_align_q <= err_align_d;
            instr_oor_q <= instr_oor_d;
            data_oor_q  <= data_oor_d;
        end
    end

    assign instr_data = instr_oor_q ? OOR_DATA : rd_data[0];
    assign data_rdata = data_oor_q  ? 32'h0    : rd_data[1];
    assign ld_ready   = (state_q == LOAD);
    assign core_run   = core_run_q;
    assign err_range  = err_range_q;
    assign err_align  = err_align_q;

endmodule

// File: tb/tb_mips_mem.sv
// Self-checking bench for mips_mem: directed scenarios plus randomized traffic
// compared against an address-arithmetic reference model.
`timescale 1ns/1ps
module tb_mips_mem;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] OOR   = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        reset_n;
    logic [31:0] instr_addr, instr_data, data_addr, data_wdata, data_rdata, ld_data;
    logic        data_rd_wr, ld_valid, ld_ready, ld_last, core_run, err_range, err_align;

    mips_mem dut (
        .clk        (clk),
        .reset      (reset_n),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rd_wr (data_rd_wr),
        .data_rdata (data_rdata),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .core_run   (core_run),
        .err_range  (err_range),
        .err_align  (err_align)
    );

    // Instance with no load phase, a non-zero base and a small array
    logic        b_reset_n;
    logic [31:0] b_instr_addr, b_instr_data, b_data_addr, b_data_wdata, b_data_rdata, b_ld_data;
    logic        b_data_rd_wr, b_ld_valid, b_ld_ready, b_ld_last, b_core_run, b_err_range, b_err_align;

    mips_mem #(
        .ADDR_BASE   (32'h0040_0000),
        .DEPTH_WORDS (16),
        .LOAD_EN     (1'b0)
    ) dut_b (
        .clk        (clk),
        .reset      (b_reset_n),
        .instr_addr (b_instr_addr),
        .instr_data (b_instr_data),
        .data_addr  (b_data_addr),
        .data_wdata (b_data_wdata),
        .data_rd_wr (b_data_rd_wr),
        .data_rdata (b_data_rdata),
        .ld_valid   (b_ld_valid),
        .ld_ready   (b_ld_ready),
        .ld_data    (b_ld_data),
        .ld_last    (b_ld_last),
        .core_run   (b_core_run),
        .err_range  (b_err_range),
        .err_align  (b_err_align)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (default instance, base 0) ----------------
    logic [31:0] m_mem [DEPTH];
    int          m_ptr;
    bit          m_running;
    logic        m_core_run, m_erange, m_ealign;
    logic [31:0] m_instr, m_data;

    task automatic model_reset();
        m_ptr      = 0;
        m_running  = 1'b0;
        m_core_run = 1'b0;
        m_erange   = 1'b0;
        m_ealign   = 1'b0;
        m_instr    = '0;
        m_data     = '0;
    endtask

    // Apply one clock edge to the model using the currently driven inputs, then
    // advance the simulation to just after that edge.
    task automatic cycle();
        if (!m_running) begin
            if (ld_valid) begin
                m_mem[m_ptr] = ld_data;
                if (ld_last || m_ptr == DEPTH - 1) m_running = 1'b1;
                else m_ptr++;
            end
        end else begin
            m_core_run = 1'b1;
            if (data_rd_wr == 1'b0) begin
                if (data_addr >= DEPTH * 4) m_erange = 1'b1;
                if (data_addr % 4 != 0)     m_ealign = 1'b1;
                if (data_addr < DEPTH * 4 && data_addr % 4 == 0)
                    m_mem[data_addr / 4] = data_wdata;
            end
            if (instr_addr >= DEPTH * 4) begin
                m_instr  = OOR;
                m_erange = 1'b1;
            end else begin
                m_instr = m_mem[instr_addr / 4];
            end
            if (instr_addr % 4 != 0) m_ealign = 1'b1;
            m_data = (data_addr >= DEPTH * 4) ? 32'h0 : m_mem[data_addr / 4];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input bit show);
        check_eq({tag, ".instr_data"}, instr_data, m_instr);
        check_eq({tag, ".data_rdata"}, data_rdata, m_data);
        check_eq({tag, ".core_run"},   32'(core_run),  32'(m_core_run));
        check_eq({tag, ".ld_ready"},   32'(ld_ready),  32'(!m_running));
        check_eq({tag, ".err_range"},  32'(err_range), 32'(m_erange));
        check_eq({tag, ".err_align"},  32'(err_align), 32'(m_ealign));
        if (show)
            $display("txn %-14s ia=%h da=%h rw=%0b wd=%h -> instr=%h rdata=%h run=%0b rdy=%0b er=%0b ea=%0b",
                     tag, instr_addr, data_addr, data_rd_wr, data_wdata,
                     instr_data, data_rdata, core_run, ld_ready, err_range, err_align);
    endtask

    task automatic idle_inputs();
        instr_addr = 32'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        data_rd_wr = 1'b1;
        ld_valid   = 1'b0;
        ld_data    = 32'h0;
        ld_last    = 1'b0;
    endtask

    // Asynchronous reset pulse, released away from the active edge.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #2;
        model_reset();
        check_all(tag, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic load_word(input logic [31:0] w, input bit last, input string tag);
        ld_valid = 1'b1;
        ld_data  = w;
        ld_last  = last;
        cycle();
        check_all(tag, 1'b1);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int          k;
        logic [31:0] a;
        k = $urandom_range(0, 31);
        if (k < 28)      a = 32'($urandom_range(0, DEPTH - 1)) * 4;
        else if (k < 30) a = 32'($urandom_range(0, DEPTH * 4 - 1));
        else             a = $urandom();
        return a;
    endfunction

    initial begin
        reset_n      = 1'b0;
        b_reset_n    = 1'b0;
        idle_inputs();
        b_instr_addr = 32'h0040_0000;
        b_data_addr  = 32'h0040_0000;
        b_data_wdata = 32'h0;
        b_data_rd_wr = 1'b1;
        b_ld_valid   = 1'b0;
        b_ld_data    = 32'h0;
        b_ld_last    = 1'b0;

        // Program load, then fetch the third word.
        do_reset("reset0");
        load_word(32'h2402_0005, 1'b0, "load0");
        load_word(32'h2403_0007, 1'b0, "load1");
        load_word(32'h0043_1021, 1'b1, "load2_last");
        instr_addr = 32'h8;
        cycle();
        check_all("fetch_0x8", 1'b1);

        // Write-first on both ports, then a plain read-back.
        data_rd_wr = 1'b0; data_addr = 32'h10; data_wdata = 32'hCAFE_0001; instr_addr = 32'h10;
        cycle();
        check_all("wr_fwd_0x10", 1'b1);
        data_rd_wr = 1'b1; instr_addr = 32'h0;
        cycle();
        check_all("rd_0x10", 1'b1);

        // Out-of-range write dropped; word 0 must be untouched.
        data_rd_wr = 1'b0; data_addr = 32'h1000; data_wdata = 32'h5555_AAAA;
        cycle();
        check_all("wr_oor", 1'b1);
        data_rd_wr = 1'b1;
        cycle();
        check_all("rd_oor", 1'b1);

        // Misaligned write dropped, out-of-range fetch.
        data_rd_wr = 1'b0; data_addr = 32'h13; data_wdata = 32'h1111_2222;
        cycle();
        check_all("wr_misalign", 1'b1);
        data_rd_wr = 1'b1; data_addr = 32'h10; instr_addr = 32'h2000;
        cycle();
        check_all("fetch_0x2000", 1'b1);

        // Reset mid-load restarts the pointer; memory is retained.
        idle_inputs();
        do_reset("reset1");
        load_word($urandom(), 1'b0, "pl0");
        load_word($urandom(), 1'b0, "pl1");
        do_reset("reset_midload");
        load_word(32'h0BAD_F00D, 1'b1, "reload0");
        data_addr = 32'h4; instr_addr = 32'h0;
        cycle();
        check_all("after_reload", 1'b1);
        data_addr = 32'h1000; instr_addr = 32'h8;
        cycle();
        check_all("rd_oor_noerr", 1'b1);

        // Full-depth load without ld_last: leaves LOAD on the last word.
        idle_inputs();
        do_reset("reset_full");
        for (int i = 0; i < 3000 && !m_running; i++) begin
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data  = $urandom();
            cycle();
            check_all("full_load", 1'b0);
        end
        check_eq("full_load.ld_ready_dropped", 32'(ld_ready), 32'h0);
        $display("txn full_load done ld_ready=%0b core_run=%0b", ld_ready, core_run);
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1'b1;
            ld_data  = $urandom();
            cycle();
            check_all("ld_ignored", 1'b0);
        end
        ld_valid = 1'b0;

        // Randomized core traffic in chunks, each starting from a fresh reset.
        for (int c = 0; c < 8; c++) begin
            idle_inputs();
            do_reset("reset_rand");
            load_word($urandom(), 1'b1, "rand_load");
            for (int i = 0; i < 150; i++) begin
                instr_addr = rand_addr();
                data_addr  = ($urandom_range(0, 3) == 0) ? instr_addr : rand_addr();
                data_wdata = $urandom();
                data_rd_wr = $urandom_range(0, 1);
                ld_valid   = $urandom_range(0, 1);
                ld_data    = $urandom();
                cycle();
                check_all("rand", 1'b0);
            end
            $display("txn rand chunk %0d done checks=%0d", c, checks);
        end
        idle_inputs();

        // No-load instance with ADDR_BASE 0x0040_0000, 16 words.
        #2;
        check_eq("b_reset.core_run", 32'(b_core_run), 32'h0);
        check_eq("b_reset.ld_ready", 32'(b_ld_ready), 32'h0);
        check_eq("b_reset.instr",    b_instr_data,     32'h0);
        @(negedge clk);
        b_reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("b_first.core_run", 32'(b_core_run), 32'h1);
        check_eq("b_first.ld_ready", 32'(b_ld_ready), 32'h0);
        b_data_addr = 32'h0040_0004; b_data_rd_wr = 1'b0; b_data_wdata = 32'h1357_9BDF;
        b_ld_valid  = 1'b1; b_ld_data = 32'hFFFF_0000; b_ld_last = 1'b1;
        @(posedge clk); #1;
        b_data_rd_wr = 1'b1; b_instr_addr = 32'h0040_0004;
        @(posedge clk); #1;
        check_eq("b_fetch_w1.instr",  b_instr_data,        32'h1357_9BDF);
        check_eq("b_fetch_w1.data",   b_data_rdata,        32'h1357_9BDF);
        check_eq("b_fetch_w1.erange", 32'(b_err_range),    32'h0);
        check_eq("b_fetch_w1.ealign", 32'(b_err_align),    32'h0);
        check_eq("b_fetch_w1.ldrdy",  32'(b_ld_ready),     32'h0);
        $display("txn b_fetch 0x00400004 -> %h", b_instr_data);
        b_instr_addr = 32'h0040_003C;
        @(posedge clk); #1;
        check_eq("b_last_word.erange", 32'(b_err_range), 32'h0);
        b_instr_addr = 32'h0040_0040; b_data_addr = 32'h0040_0040;
        @(posedge clk); #1;
        check_eq("b_oor.instr",  b_instr_data,     OOR);
        check_eq("b_oor.data",   b_data_rdata,     32'h0);
        check_eq("b_oor.erange", 32'(b_err_range), 32'h1);
        $display("txn b_fetch 0x00400040 -> %h err_range=%0b", b_instr_data, b_err_range);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
